// File: rtl/parser_check_pkg.sv
// parser_check_pkg: shared types for the parser stream checker.
// State encodings, error codes and the expected-beat record stored in
// the check table. The record widths follow the package geometry below,
// which is also the default geometry of parser_stream_checker.
package parser_check_pkg;

    localparam int unsigned PC_DATA_W = 64;
    localparam int unsigned PC_BV_W   = PC_DATA_W / 8;
    localparam int unsigned PC_LANES  = 16;
    localparam int unsigned PC_LANE_W = $clog2(PC_LANES);
    localparam int unsigned PC_ADDR_W = 9;
    localparam int unsigned PC_DEPTH  = 16;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ARMED = 4'd1,
        CHECK = 4'd2,
        PASS  = 4'd14,
        FAIL  = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_LANE    = 3'd1,
        ERR_BV      = 3'd2,
        ERR_DATA    = 3'd3,
        ERR_ADDR    = 3'd4,
        ERR_MULTI   = 3'd5,
        ERR_TIMEOUT = 3'd6
    } err_e;

    typedef struct packed {
        logic [PC_DATA_W-1:0] data;
        logic [PC_BV_W-1:0]   bv;
        logic [PC_LANE_W-1:0] lane;
    } beat_t;

    // True when more than one bit of the lane vector is set.
    function automatic logic is_multi_hot(input logic [PC_LANES-1:0] v);
        return (v & (v - {{(PC_LANES-1){1'b0}}, 1'b1})) != {PC_LANES{1'b0}};
    endfunction

endpackage

// File: rtl/parser_stream_checker_if.sv
// parser_stream_checker_if: the parser output stream as seen by the checker.
// The parser side drives (master); the checker only observes (slave).
interface parser_stream_checker_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned LANES  = 16
);
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W/8-1:0] byte_valid;
    logic [ADDR_W-1:0]   address;
    logic [LANES-1:0]    valid;

    modport master (output data_in, output byte_valid, output address, output valid);
    modport slave  (input  data_in, input  byte_valid, input  address, input  valid);
endinterface

// File: rtl/parser_check_table.sv
// parser_check_table: expected-beat table. Synchronous write, combinational
// read by beat index. Contents are deliberately not reset so a table loaded
// before a reset pulse survives it.
module parser_check_table
    import parser_check_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  beat_t            i_wentry,
    input  logic [IDX_W-1:0] i_ridx,
    output beat_t            o_rentry
);

    beat_t r_mem [DEPTH];

    // Table write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wentry;
        end
    end

    assign o_rentry = r_mem[i_ridx];

endmodule

// File: rtl/parser_stream_checker.sv
// parser_stream_checker: passive in-circuit checker for the parser stream.
// Compares each beat (valid != 0) against the next table entry, ends in a
// sticky PASS or FAIL and keeps the beat index and cause of the first error.
// Outputs are a registered copy of the internal state, one cycle behind.
// Optional build macro PARSER_CHECK_TIMEOUT_EN adds an idle watchdog that
// fails the check after TIMEOUT_CYC consecutive beat-free cycles.
module parser_stream_checker
    import parser_check_pkg::*;
#(
    parameter int unsigned DATA_W      = PC_DATA_W,
    parameter int unsigned BV_W        = DATA_W / 8,
    parameter int unsigned LANES       = PC_LANES,
    parameter int unsigned ADDR_W      = PC_ADDR_W,
    parameter int unsigned DEPTH       = PC_DEPTH,
    parameter int unsigned IDX_W       = $clog2(DEPTH),
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cfg_we,
    input  logic [IDX_W-1:0]         i_cfg_idx,
    input  logic [DATA_W-1:0]        i_cfg_data,
    input  logic [BV_W-1:0]          i_cfg_bv,
    input  logic [$clog2(LANES)-1:0] i_cfg_lane,
    input  logic [IDX_W:0]           i_cfg_len,
    input  logic [ADDR_W-1:0]        i_cfg_base,
    input  logic                     i_start,
    parser_stream_checker_if.slave   s_stream,
    output logic [3:0]               o_state_out,
    output logic                     o_done,
    output logic                     o_pass,
    output logic [IDX_W:0]           o_err_beat,
    output logic [2:0]               o_err_code
);

    localparam logic [IDX_W:0] BEAT_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_e               r_state, w_state_nxt;
    logic [IDX_W:0]       r_beat, w_beat_nxt;
    logic [IDX_W:0]       r_len, w_len_nxt;
    logic [ADDR_W-1:0]    r_base, w_base_nxt;
    logic [IDX_W:0]       r_err_beat, w_err_beat_nxt;
    err_e                 r_err_code, w_err_code_nxt;

    beat_t                w_entry;
    beat_t                w_cfg_entry;
    logic                 w_cfg_open;
    logic                 w_is_beat;
    logic [LANES-1:0]     w_exp_valid;
    logic [ADDR_W-1:0]    w_exp_addr;
    logic [DATA_W-1:0]    w_diff;
    logic [BV_W-1:0]      w_byte_bad;
    logic [IDX_W:0]       w_last_beat;
    err_e                 w_err_kind;

`ifdef PARSER_CHECK_TIMEOUT_EN
    localparam int unsigned  WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] r_wdog, w_wdog_nxt;
`endif

    // Table writes are only honoured while no check is running.
    assign w_cfg_open  = (r_state == IDLE) || (r_state == PASS) || (r_state == FAIL);
    assign w_cfg_entry = '{data: i_cfg_data, bv: i_cfg_bv, lane: i_cfg_lane};

    parser_check_table #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk      (clk),
        .i_we     (i_cfg_we && w_cfg_open),
        .i_widx   (i_cfg_idx),
        .i_wentry (w_cfg_entry),
        .i_ridx   (r_beat[IDX_W-1:0]),
        .o_rentry (w_entry)
    );

    assign w_is_beat   = |s_stream.valid;
    assign w_exp_valid = {{(LANES-1){1'b0}}, 1'b1} << w_entry.lane;
    assign w_exp_addr  = r_base + ADDR_W'(r_beat);
    assign w_diff      = s_stream.data_in ^ w_entry.data;
    assign w_last_beat = r_len - BEAT_ONE;

    // Per-byte data mismatch, masked by the expected byte-valid.
    always_comb begin
        w_byte_bad = '0;
        for (int b = 0; b < int'(BV_W); b++) begin
            w_byte_bad[b] = w_entry.bv[b] & (|w_diff[b*8 +: 8]);
        end
    end

    // Classify the current beat; checks are in strict priority order.
    always_comb begin
        w_err_kind = ERR_NONE;
        if (is_multi_hot(s_stream.valid)) begin
            w_err_kind = ERR_MULTI;
        end else if (s_stream.valid != w_exp_valid) begin
            w_err_kind = ERR_LANE;
        end else if (s_stream.byte_valid != w_entry.bv) begin
            w_err_kind = ERR_BV;
        end else if (s_stream.address != w_exp_addr) begin
            w_err_kind = ERR_ADDR;
        end else if (|w_byte_bad) begin
            w_err_kind = ERR_DATA;
        end else begin
            w_err_kind = ERR_NONE;
        end
    end

    // Next-state logic: start always wins, then per-state beat handling.
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_nxt     = r_beat;
        w_len_nxt      = r_len;
        w_base_nxt     = r_base;
        w_err_beat_nxt = r_err_beat;
        w_err_code_nxt = r_err_code;
`ifdef PARSER_CHECK_TIMEOUT_EN
        w_wdog_nxt     = '0;
`endif
        if (i_start) begin
            w_beat_nxt     = '0;
            w_err_beat_nxt = '0;
            w_err_code_nxt = ERR_NONE;
            w_len_nxt      = i_cfg_len;
            w_base_nxt     = i_cfg_base;
            w_state_nxt    = (i_cfg_len == '0) ? PASS : ARMED;
        end else begin
            case (r_state)
                ARMED, CHECK: begin
                    if (w_is_beat) begin
                        if (w_err_kind != ERR_NONE) begin
                            w_state_nxt    = FAIL;
                            w_err_beat_nxt = r_beat;
                            w_err_code_nxt = w_err_kind;
                        end else begin
                            w_beat_nxt  = r_beat + BEAT_ONE;
                            w_state_nxt = (r_beat == w_last_beat) ? PASS : CHECK;
                        end
                    end else begin
`ifdef PARSER_CHECK_TIMEOUT_EN
                        if (r_wdog == WD_LAST) begin
                            w_state_nxt    = FAIL;
                            w_err_beat_nxt = r_beat;
                            w_err_code_nxt = ERR_TIMEOUT;
                        end else begin
                            w_wdog_nxt = r_wdog + WD_W'(1);
                        end
`else
                        w_state_nxt = r_state;
`endif
                    end
                end
                IDLE, PASS, FAIL: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Internal state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_len      <= '0;
            r_base     <= '0;
            r_err_beat <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_beat     <= w_beat_nxt;
            r_len      <= w_len_nxt;
            r_base     <= w_base_nxt;
            r_err_beat <= w_err_beat_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

`ifdef PARSER_CHECK_TIMEOUT_EN
    // Idle watchdog counter; cleared by any beat, by start and outside a check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_nxt;
        end
    end
`endif

    // Registered status outputs, one cycle behind the internal state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_state_out <= 4'd0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_err_beat  <= '0;
            o_err_code  <= 3'd0;
        end else begin
            o_state_out <= r_state;
            o_done      <= (r_state == PASS) || (r_state == FAIL);
            o_pass      <= (r_state == PASS);
            o_err_beat  <= r_err_beat;
            o_err_code  <= r_err_code;
        end
    end

endmodule

// File: doc/parser_stream_checker.md
Name: parser_stream_checker

Overview:
- Programmable in-circuit checker for the parser output stream: data beats, byte-valid mask, write address and per-lane one-hot valid.
- Holds a table of expected beats and compares each incoming beat against the next entry. Ends in a sticky PASS or FAIL state and captures details of the first error.
- Sits beside the parser/decompressor datapath as a debug and bring-up monitor; purely passive, with no backpressure on the stream.

Parameters:
- DATA_W, 64, stream data width in bits; multiple of 8.
- BV_W, DATA_W/8, byte-valid width (derived).
- LANES, 16, width of the valid vector (one bit per lane).
- ADDR_W, 9, stream address width.
- DEPTH, 16, number of expected-beat table entries; power of 2.
- IDX_W, $clog2(DEPTH), table index width (derived).
- TIMEOUT_CYC, 1024, idle watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  table write strobe; accepted only in IDLE, PASS or FAIL.
- cfg_idx  in  IDX_W  table entry written.
- cfg_data  in  DATA_W  expected data.
- cfg_bv  in  BV_W  expected byte_valid.
- cfg_lane  in  $clog2(LANES)  expected lane (valid bit index).
- cfg_len  in  IDX_W+1  number of beats to check, 0..DEPTH.
- cfg_base  in  ADDR_W  expected address of beat 0.
- start  in  1  single-cycle arm pulse.
- data_in  in  DATA_W  stream data.
- byte_valid  in  BV_W  stream byte mask; bit BV_W-1 = data_in[DATA_W-1:DATA_W-8].
- address  in  ADDR_W  stream address.
- valid  in  LANES  beat qualifier; a beat is any cycle with valid != 0.
- state_out  out  4  registered state, one cycle behind internal state.
- done  out  1  registered; high in PASS or FAIL.
- pass  out  1  registered; high in PASS.
- err_beat  out  IDX_W+1  beat index of the first failure.
- err_code  out  3  cause of the first failure.

Behaviour:
- Reset values:
  - Internal state = IDLE; beat counter = 0.
  - state_out = 0, done = 0, pass = 0, err_beat = 0, err_code = 0.
  - Table contents are not reset.
- State encodings: IDLE = 0, ARMED = 1, CHECK = 2, PASS = 14, FAIL = 15.
- IDLE: start -> ARMED. At the same time: clear beat counter, err_beat and err_code; latch cfg_len and cfg_base.
  - If cfg_len = 0, start goes directly to PASS.
- ARMED and CHECK, on each beat, compare against table entry [beat]. Mismatch checks in priority order:
  - multi-hot valid (popcount > 1): err 5.
  - valid != onehot(lane): err 1.
  - byte_valid != bv: err 2.
  - address != (base + beat) mod 2^ADDR_W: err 4.
  - (data_in ^ exp_data) nonzero in any byte where bv = 1: err 3. Bytes with bv = 0 are don't-care.
- Any mismatch -> FAIL; capture err_beat = beat and err_code.
- Match -> beat + 1. The first matched beat moves ARMED -> CHECK. A match on beat = len-1 -> PASS.
- Non-beat cycles: hold state.
- PASS and FAIL are sticky; only start (re-arm, as from IDLE) or reset leaves them.
- start in ARMED or CHECK restarts the check from beat 0. If start coincides with a beat, start wins and the beat is ignored.
- cfg_we in ARMED or CHECK is ignored.
- Beats are ignored in IDLE, PASS and FAIL.
- Latency: all outputs are registered one cycle after the internal state update. The decision for a beat at edge N is visible on state_out, done and pass after edge N+1.
- Reset mid-check returns to IDLE with outputs cleared on the next edge.

Optional Feature:
- Macro PARSER_CHECK_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive non-beat cycles in ARMED or CHECK; it clears on any beat or on start.
  - Reaching TIMEOUT_CYC -> FAIL, err_code 6, err_beat = current beat.
- Undefined: no counter, no timeout; code 6 is never produced.

Decomposition:
- Package parser_check_pkg holds:
  - the state encodings (IDLE, ARMED, CHECK, PASS, FAIL);
  - the error codes (ERR_NONE = 0, ERR_LANE = 1, ERR_BV = 2, ERR_DATA = 3, ERR_ADDR = 4, ERR_MULTI = 5, ERR_TIMEOUT = 6);
  - the expected-beat struct {data, bv, lane}.
- One sub-module, parser_check_table: a DEPTH-entry register table with synchronous write and asynchronous read by beat index.

Test Plan:
- cfg_len = 1, base = 0, entry0 {data 0x0d0a_xxxx_xxxx_xxxx, bv 0xC0, lane 0}, start; drive valid 0x0001, data[63:48] = 0x0d0a, bv 0xC0, addr 0 -> state_out 14, pass = 1, done = 1 on the 2nd edge.
- Same setup, drive valid 0x0002 -> FAIL: state_out 15, err_code 1, err_beat 0.
- cfg_len = 4, base = 0x1FE, correct data with addresses 0x1FE, 0x1FF, 0x000, 0x001 (address wrap) -> PASS. Repeat with the 3rd address = 0x100 -> err_code 4, err_beat 2.
- 3 matching beats, then a beat with valid 0x0003 -> err_code 5, err_beat 3. Then pulse start and replay the correct beats -> PASS; err_code reads 0 after re-arm.
- Beat with data differing only in a byte where bv = 0 -> match. Beat with the same byte differing where bv = 1 -> err_code 3.
- With PARSER_CHECK_TIMEOUT_EN and TIMEOUT_CYC = 8: start, then no beats -> FAIL, err_code 6, on the 8th idle cycle. Without the macro, the state stays ARMED indefinitely.
